dsp_rdata_ordered: RTL and testbench
====================================

// Module: dsp_rdata_ordered
// PURPOSE
//  Next-gen R-channel dispatcher on the master side of the interconnect. Buffers read beats per slave and
//  tracks AR dispatch order internally in an ordering queue. The master sees bursts in AR-issue order, with
//  no external slave-select. A burst is retired on its RLAST beat.
// PARAMETERS
//  SLV_AMT          4   number of slave-arbitration ports
//  DATA_WIDTH       32  RDATA width
//  TRANS_MST_ID_W   5   RID width
//  TRANS_RESP_W     2   RRESP width
//  SLV_ID_W         $clog2(SLV_AMT), min 1; slave index width
//  DSP_RDATA_DEPTH  16  per-slave beat FIFO depth (power of 2, >=2)
//  OUTST_DEPTH      8   max outstanding read bursts in the order queue (power of 2, >=2)
// PORTS
//  ACLK_i          in   1                      clock, rising edge
//  ARESET_i        in   1                      reset, asynchronous, active-high
//  ar_push_i       in   1                      AR handshake to slave committed this cycle
//  ar_slv_id_i     in   SLV_ID_W               target slave of that AR
//  ar_ord_full_o   out  1                      order queue full; upstream must stall AR
//  ar_outst_cnt_o  out  $clog2(OUTST_DEPTH+1)  bursts outstanding
//  sa_RID_i        in   TRANS_MST_ID_W*SLV_AMT packed per slave, slave 0 in LSBs
//  sa_RDATA_i      in   DATA_WIDTH*SLV_AMT     packed per slave
//  sa_RRESP_i      in   TRANS_RESP_W*SLV_AMT   packed per slave
//  sa_RLAST_i      in   SLV_AMT                per slave
//  sa_RVALID_i     in   SLV_AMT                per slave
//  sa_RREADY_o     out  SLV_AMT                per slave = FIFO not full
//  m_RID_o/m_RDATA_o/m_RRESP_o/m_RLAST_o  out  widths as above   beat to master
//  m_RVALID_o      out  1                      beat valid
//  m_RREADY_i      in   1                      master ready
// BEHAVIOUR
//  Reset: async clear of all FIFOs, the order queue and the counter.
//   - Outputs during and after reset: m_RVALID_o=0, m_R* payload=0, ar_ord_full_o=0, ar_outst_cnt_o=0.
//   - sa_RREADY_o is forced 0 while ARESET_i is high, then all 1s.
//   - Reset mid-burst drops all buffered beats and order entries; no partial beats survive.
//  Slave side:
//   - Beat k is written when sa_RVALID_i[k] & sa_RREADY_o[k] are both high.
//   - Slaves are independent; up to SLV_AMT writes per cycle.
//  Order queue: FIFO of slave ids.
//   - Pushed on ar_push_i; head = current source slave.
//   - Popped on the master handshake of the beat with RLAST=1.
//   - Push and pop in the same cycle leave the count unchanged; this is legal when full.
//   - Push when full without a pop is dropped; this is an upstream protocol error (bench asserts).
//  Master side:
//   - m_RVALID_o = order queue not empty & FIFO[head] not empty.
//   - Payload = FIFO[head] output.
//   - Handshake pops FIFO[head]. The RLAST beat also pops the order queue, so the next burst's head is
//     used from the next cycle.
//   - Beats from non-head slaves stay buffered and backpressure via sa_RREADY_o when full.
//   - Beats arriving with an empty order queue are buffered, never forwarded until ordered.
//  Latency: beat accepted from a slave at cycle N is visible on m_R* at N+1 (no bypass). Throughput is
//   1 beat/cycle.
//  Boundaries:
//   - Full FIFO: sa_RREADY_o=0; no simultaneous read-frees-write path.
//   - Empty: no read.
//   - Pointers wrap modulo depth.
//   - ar_outst_cnt_o saturates at OUTST_DEPTH, never exceeds it.
//   - RID is forwarded unchanged.
// CONFIGURATION
//  DSP_R_OUT_REG_EN defined:
//   - a 2-entry skid buffer registers all m_R* outputs.
//   - Slave-to-master latency becomes N+2; full throughput is kept.
//   - m_RREADY_i has no combinational path to FIFO read enables.
//   - The order-queue pop occurs when the RLAST beat enters the skid buffer.
//  Undefined: m_R* are combinational from FIFO[head] as described above.
// STRUCTURE
//  Shared package dsp_pkg:
//   - DATA_INFO_W = TRANS_MST_ID_W+DATA_WIDTH+TRANS_RESP_W+1.
//   - Beat field order {RID,RDATA,RRESP,RLAST}.
//  Reuses the codebase sync FIFO for the per-slave beat FIFOs and the order queue.
//  Sub-module: dsp_r_skid_buf (2-entry valid/ready register slice), instantiated only under DSP_R_OUT_REG_EN.
// TESTING
//  1. Single burst:
//     - Stimulus: push slv1; slave1 sends 4 beats with RDATA 0xA0..0xA3, RLAST on beat 3; m_RREADY=1.
//     - Expect: 4 beats in order, RLAST on the 4th; ar_outst_cnt 1->0.
//  2. Reordering:
//     - Stimulus: push slv2 then slv0; slave0 returns its 2-beat burst before slave2's.
//     - Expect: slave2's beats appear first, then slave0's.
//  3. Backpressure:
//     - Stimulus: m_RREADY=0, push slv0; slave0 streams 20 beats.
//     - Expect: sa_RREADY_o[0]=0 after 16 accepted. Release: 20 beats with no loss or duplication.
//  4. Order full:
//     - Stimulus: 8 pushes with no returns.
//     - Expect: ar_ord_full_o=1, cnt=8.
//     - Then: push+RLAST pop in the same cycle keeps cnt=8, and the entry is accepted.
//  5. Reset mid-burst:
//     - Stimulus: assert ARESET_i after 2 of 4 beats.
//     - Expect: m_RVALID_o=0 immediately (async); cnt=0; sa_RREADY_o=0 during reset, all 1 after.
//  6. DSP_R_OUT_REG_EN:
//     - Rerun tests 1 and 3; expect latency N+2, identical beat sequence, and 1 beat/cycle sustained.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants and types for the read-data dispatch path.
// Beat records are packed {RID, RDATA, RRESP, RLAST}, so RLAST is always bit 0.
package dsp_pkg;

   localparam int DSP_TRANS_MST_ID_W = 5;
   localparam int DSP_DATA_WIDTH     = 32;
   localparam int DSP_TRANS_RESP_W   = 2;
   localparam int DATA_INFO_W        = DSP_TRANS_MST_ID_W + DSP_DATA_WIDTH + DSP_TRANS_RESP_W + 1;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_t;

   function automatic int dsp_slv_id_w(input int slv_amt);
      return (slv_amt > 1) ? $clog2(slv_amt) : 1;
   endfunction

endpackage

// File: rtl/dsp_r_skid_buf.sv
// Two-entry valid/ready register slice; s_rdy is registered state only (no path from m_rdy).
// Built only when DSP_R_OUT_REG_EN is defined; adds one cycle of latency at full throughput.
`ifdef DSP_R_OUT_REG_EN
module dsp_r_skid_buf
   import dsp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_vld,
   output logic             s_rdy,
   input  logic [WIDTH-1:0] s_dat,
   output logic             m_vld,
   input  logic             m_rdy,
   output logic [WIDTH-1:0] m_dat
);

   skid_state_t      state;
   skid_state_t      state_nxt;
   logic [WIDTH-1:0] dat0;
   logic [WIDTH-1:0] dat1;
   logic             push;
   logic             pop;
   logic             ld0_in;
   logic             ld0_from1;
   logic             ld1_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SKID_EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      s_rdy     = (state != SKID_TWO);
      m_vld     = (state != SKID_EMPTY);
      push      = s_vld & s_rdy;
      pop       = m_vld & m_rdy;
      ld0_in    = 1'b0;
      ld0_from1 = 1'b0;
      ld1_in    = 1'b0;
      case (state)
         SKID_EMPTY: begin
            if (push) begin
               state_nxt = SKID_ONE;
               ld0_in    = 1'b1;
            end
         end
         SKID_ONE: begin
            if (push && pop) begin
               ld0_in = 1'b1;
            end else if (push) begin
               state_nxt = SKID_TWO;
               ld1_in    = 1'b1;
            end else if (pop) begin
               state_nxt = SKID_EMPTY;
            end
         end
         SKID_TWO: begin
            if (pop) begin
               state_nxt = SKID_ONE;
               ld0_from1 = 1'b1;
            end
         end
         default: state_nxt = SKID_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dat0 <= '0;
         dat1 <= '0;
      end else begin
         if (ld0_in)         dat0 <= s_dat;
         else if (ld0_from1) dat0 <= dat1;
         if (ld1_in)         dat1 <= s_dat;
      end
   end

   assign m_dat = m_vld ? dat0 : '0;

endmodule
`endif

// File: rtl/dsp_sync_fifo.sv
// Synchronous FIFO with fall-through read data; no bypass, so a write is readable the next cycle.
// A write while full is accepted only when a read frees the slot in the same cycle.
module dsp_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Extra pointer MSB distinguishes full from empty when the indices meet.
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd  = rd_en & ~empty;
   assign do_wr  = wr_en & (~full | do_rd);
   assign rd_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

endmodule

// File: rtl/dsp_rdata_ordered.sv
// Per-slave R beat buffers drained to the master in AR-issue order; a burst retires on its RLAST beat.
// Beat visible at N+1 (N+2 with DSP_R_OUT_REG_EN, which adds an output skid buffer); slaves stall on FIFO full.
module dsp_rdata_ordered
   import dsp_pkg::*;
#(
   parameter  int SLV_AMT         = 4,
   parameter  int DATA_WIDTH      = DSP_DATA_WIDTH,
   parameter  int TRANS_MST_ID_W  = DSP_TRANS_MST_ID_W,
   parameter  int TRANS_RESP_W    = DSP_TRANS_RESP_W,
   parameter  int DSP_RDATA_DEPTH = 16,
   parameter  int OUTST_DEPTH     = 8,
   localparam int SLV_ID_W        = dsp_slv_id_w(SLV_AMT),
   localparam int CNT_W           = $clog2(OUTST_DEPTH + 1)
) (
   input  logic                               ACLK_i,
   input  logic                               ARESET_i,
   input  logic                               ar_push_i,
   input  logic [SLV_ID_W-1:0]                ar_slv_id_i,
   output logic                               ar_ord_full_o,
   output logic [CNT_W-1:0]                   ar_outst_cnt_o,
   input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]  sa_RID_i,
   input  logic [DATA_WIDTH*SLV_AMT-1:0]      sa_RDATA_i,
   input  logic [TRANS_RESP_W*SLV_AMT-1:0]    sa_RRESP_i,
   input  logic [SLV_AMT-1:0]                 sa_RLAST_i,
   input  logic [SLV_AMT-1:0]                 sa_RVALID_i,
   output logic [SLV_AMT-1:0]                 sa_RREADY_o,
   output logic [TRANS_MST_ID_W-1:0]          m_RID_o,
   output logic [DATA_WIDTH-1:0]              m_RDATA_o,
   output logic [TRANS_RESP_W-1:0]            m_RRESP_o,
   output logic                               m_RLAST_o,
   output logic                               m_RVALID_o,
   input  logic                               m_RREADY_i
);

   localparam int               DINFO_W = TRANS_MST_ID_W + DATA_WIDTH + TRANS_RESP_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DINFO_W-1:0]  beat_wr [SLV_AMT];
   logic [DINFO_W-1:0]  beat_rd [SLV_AMT];
   logic [SLV_AMT-1:0]  beat_wr_en;
   logic [SLV_AMT-1:0]  beat_rd_en;
   logic [SLV_AMT-1:0]  beat_full;
   logic [SLV_AMT-1:0]  beat_empty;

   logic [SLV_ID_W-1:0] ord_head;
   logic                ord_full;
   logic                ord_empty;
   logic                ord_push;
   logic                ord_pop;
   logic [CNT_W-1:0]    outst_cnt;

   logic [DINFO_W-1:0]  head_dat;
   logic                head_has;
   logic                src_vld;
   logic                src_rdy;
   logic                src_hs;
   logic                out_vld;
   logic [DINFO_W-1:0]  out_dat;

   for (genvar k = 0; k < SLV_AMT; k++) begin : g_slv
      assign beat_wr[k] = {sa_RID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W],
                           sa_RDATA_i[k*DATA_WIDTH +: DATA_WIDTH],
                           sa_RRESP_i[k*TRANS_RESP_W +: TRANS_RESP_W],
                           sa_RLAST_i[k]};
      // Ready depends only on local fullness: a full FIFO never accepts even if it is read this cycle.
      assign sa_RREADY_o[k] = ~beat_full[k] & ~ARESET_i;
      assign beat_wr_en[k]  = sa_RVALID_i[k] & sa_RREADY_o[k];

      dsp_sync_fifo #(
         .WIDTH (DINFO_W),
         .DEPTH (DSP_RDATA_DEPTH)
      ) u_beat_fifo (
         .clk    (ACLK_i),
         .rst    (ARESET_i),
         .wr_en  (beat_wr_en[k]),
         .wr_dat (beat_wr[k]),
         .rd_en  (beat_rd_en[k]),
         .rd_dat (beat_rd[k]),
         .full   (beat_full[k]),
         .empty  (beat_empty[k])
      );
   end

   dsp_sync_fifo #(
      .WIDTH (SLV_ID_W),
      .DEPTH (OUTST_DEPTH)
   ) u_ord_fifo (
      .clk    (ACLK_i),
      .rst    (ARESET_i),
      .wr_en  (ord_push),
      .wr_dat (ar_slv_id_i),
      .rd_en  (ord_pop),
      .rd_dat (ord_head),
      .full   (ord_full),
      .empty  (ord_empty)
   );

   always_comb begin
      head_dat = '0;
      head_has = 1'b0;
      for (int k = 0; k < SLV_AMT; k++) begin
         if (ord_head == SLV_ID_W'(k)) begin
            head_dat = beat_rd[k];
            head_has = ~beat_empty[k];
         end
      end
   end

   assign src_vld  = ~ord_empty & head_has;
   assign src_hs   = src_vld & src_rdy;
   assign ord_pop  = src_hs & head_dat[0];
   assign ord_push = ar_push_i & (~ord_full | ord_pop);

   always_comb begin
      beat_rd_en = '0;
      for (int k = 0; k < SLV_AMT; k++) begin
         beat_rd_en[k] = src_hs & (ord_head == SLV_ID_W'(k));
      end
   end

   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i)                 outst_cnt <= '0;
      else if (ord_push & ~ord_pop) outst_cnt <= outst_cnt + CNT_ONE;
      else if (ord_pop & ~ord_push) outst_cnt <= outst_cnt - CNT_ONE;
   end

   assign ar_ord_full_o  = ord_full;
   assign ar_outst_cnt_o = outst_cnt;

`ifdef DSP_R_OUT_REG_EN
   dsp_r_skid_buf #(
      .WIDTH (DINFO_W)
   ) u_out_skid (
      .clk   (ACLK_i),
      .rst   (ARESET_i),
      .s_vld (src_vld),
      .s_rdy (src_rdy),
      .s_dat (head_dat),
      .m_vld (out_vld),
      .m_rdy (m_RREADY_i),
      .m_dat (out_dat)
   );
`else
   assign src_rdy = m_RREADY_i;
   assign out_vld = src_vld;
   assign out_dat = src_vld ? head_dat : '0;
`endif

   assign m_RVALID_o = out_vld;
   assign {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o} = out_dat;

endmodule

// File: tb/tb_dsp_rdata_ordered.sv
// Directed bench for dsp_rdata_ordered: ordering, backpressure, order-queue full and async reset.
module tb_dsp_rdata_ordered;

`ifdef DSP_R_OUT_REG_EN
   localparam int LAT  = 2;
   localparam int BUFD = 18;
`else
   localparam int LAT  = 1;
   localparam int BUFD = 16;
`endif

   logic         ACLK = 1'b0;
   logic         ARESET = 1'b0;
   logic         ar_push = 1'b0;
   logic [1:0]   ar_id = '0;
   logic         ar_full;
   logic [3:0]   ar_cnt;
   logic [19:0]  sa_rid = '0;
   logic [127:0] sa_rdata = '0;
   logic [7:0]   sa_rresp = '0;
   logic [3:0]   sa_rlast = '0;
   logic [3:0]   sa_rvalid = '0;
   logic [3:0]   sa_rready;
   logic [4:0]   m_rid;
   logic [31:0]  m_rdata;
   logic [1:0]   m_rresp;
   logic         m_rlast;
   logic         m_rvalid;
   logic         m_rready = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int wcyc;
   int n;
   logic acc;

   logic [31:0] q_dat [$];
   logic        q_last[$];
   logic [4:0]  q_id  [$];
   logic [1:0]  q_resp[$];
   int          q_cyc [$];

   dsp_rdata_ordered dut (
      .ACLK_i         (ACLK),
      .ARESET_i       (ARESET),
      .ar_push_i      (ar_push),
      .ar_slv_id_i    (ar_id),
      .ar_ord_full_o  (ar_full),
      .ar_outst_cnt_o (ar_cnt),
      .sa_RID_i       (sa_rid),
      .sa_RDATA_i     (sa_rdata),
      .sa_RRESP_i     (sa_rresp),
      .sa_RLAST_i     (sa_rlast),
      .sa_RVALID_i    (sa_rvalid),
      .sa_RREADY_o    (sa_rready),
      .m_RID_o        (m_rid),
      .m_RDATA_o      (m_rdata),
      .m_RRESP_o      (m_rresp),
      .m_RLAST_o      (m_rlast),
      .m_RVALID_o     (m_rvalid),
      .m_RREADY_i     (m_rready)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) cyc <= cyc + 1;

   // A beat seen valid+ready at the falling edge completes its handshake at the next rising edge.
   always @(negedge ACLK) begin
      if (m_rvalid && m_rready) begin
         q_dat.push_back(m_rdata);
         q_last.push_back(m_rlast);
         q_id.push_back(m_rid);
         q_resp.push_back(m_rresp);
         q_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge ACLK);
      #1;
   endtask

   // Slave k always sends RID k+1 and RRESP k so forwarding of those fields is visible.
   task automatic drive(input int k, input logic [31:0] d, input logic last, input logic vld);
      sa_rdata[k*32 +: 32] = d;
      sa_rid[k*5 +: 5]     = 5'(k + 1);
      sa_rresp[k*2 +: 2]   = 2'(k);
      sa_rlast[k]          = last;
      sa_rvalid[k]         = vld;
   endtask

   task automatic push_ar(input logic [1:0] id);
      ar_push = 1'b1;
      ar_id   = id;
      tick();
      ar_push = 1'b0;
   endtask

   task automatic clear_q;
      q_dat.delete();
      q_last.delete();
      q_id.delete();
      q_resp.delete();
      q_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [31:0] exp2 [5] = '{32'hC0, 32'hC1, 32'hC2, 32'hB0, 32'hB1};

   initial begin
      // ---- reset state
      #1 ARESET = 1'b1;
      #1;
      chk("rst_rvalid", m_rvalid, 1'b0);
      chk("rst_rdata", m_rdata, 32'h0);
      chk("rst_cnt", ar_cnt, 4'd0);
      chk("rst_full", ar_full, 1'b0);
      chk("rst_rready", sa_rready, 4'h0);
      @(posedge ACLK);
      @(posedge ACLK);
      #3 ARESET = 1'b0;
      tick();
      chk("rst_rready_after", sa_rready, 4'hF);
      chk("rst_rvalid_after", m_rvalid, 1'b0);

      // ---- test 1: single 4-beat burst from slave 1
      m_rready = 1'b1;
      clear_q();
      push_ar(2'd1);
      chk("t1_cnt_push", ar_cnt, 4'd1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'hA0 + i, i == 3, 1'b1);
         tick();
         if (i == 0) begin
            wcyc = cyc;
            chk("t1_first_vld", m_rvalid, (LAT == 1));
         end
      end
      drive(1, 32'h0, 1'b0, 1'b0);
      repeat (4) tick();
      chk("t1_nbeats", q_dat.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_data", q_dat[i], 32'hA0 + i);
         chk("t1_last", q_last[i], (i == 3));
      end
      chk("t1_rid", q_id[0], 5'd2);
      chk("t1_rresp", q_resp[0], 2'd1);
      chk("t1_latency", q_cyc[0] - wcyc, LAT - 1);
      chk("t1_thruput", q_cyc[3] - q_cyc[0], 3);
      chk("t1_cnt_end", ar_cnt, 4'd0);

      // ---- test 2: slave 0 answers first but slave 2 was ordered first
      clear_q();
      push_ar(2'd2);
      push_ar(2'd0);
      chk("t2_cnt", ar_cnt, 4'd2);
      drive(0, 32'hB0, 1'b0, 1'b1);
      tick();
      drive(0, 32'hB1, 1'b1, 1'b1);
      tick();
      drive(0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("t2_hold", m_rvalid, 1'b0);
      drive(2, 32'hC0, 1'b0, 1'b1);
      tick();
      drive(2, 32'hC1, 1'b0, 1'b1);
      tick();
      drive(2, 32'hC2, 1'b1, 1'b1);
      tick();
      drive(2, 32'h0, 1'b0, 1'b0);
      repeat (6) tick();
      chk("t2_nbeats", q_dat.size(), 5);
      for (int i = 0; i < 5; i++) chk("t2_order", q_dat[i], exp2[i]);
      chk("t2_last_c", q_last[2], 1'b1);
      chk("t2_last_b", q_last[4], 1'b1);
      chk("t2_rid_b", q_id[3], 5'd1);
      chk("t2_cnt_end", ar_cnt, 4'd0);

      // ---- test 3: backpressure with 20 beats from slave 0
      m_rready = 1'b0;
      clear_q();
      push_ar(2'd0);
      n = 0;
      for (int c = 0; c < 22; c++) begin
         drive(0, 32'h100 + n, n == 19, 1'b1);
         acc = sa_rready[0];
         tick();
         if (acc) n++;
      end
      chk("t3_accepted", n, BUFD);
      chk("t3_rready", sa_rready, 4'b1110);
      chk("t3_nofwd", q_dat.size(), 0);
      m_rready = 1'b1;
      for (int c = 0; c < 200 && n < 20; c++) begin
         drive(0, 32'h100 + n, n == 19, 1'b1);
         acc = sa_rready[0];
         tick();
         if (acc) n++;
      end
      drive(0, 32'h0, 1'b0, 1'b0);
      chk("t3_all_sent", n, 20);
      repeat (25) tick();
      chk("t3_nbeats", q_dat.size(), 20);
      for (int i = 0; i < 20; i++) begin
         chk("t3_data", q_dat[i], 32'h100 + i);
         chk("t3_last", q_last[i], (i == 19));
      end
      chk("t3_thruput", q_cyc[19] - q_cyc[0], 19);
      chk("t3_cnt_end", ar_cnt, 4'd0);

      // ---- test 4: order queue full, drop, and push+pop when full
      clear_q();
      ar_push = 1'b1;
      ar_id   = 2'd3;
      repeat (8) tick();
      ar_push = 1'b0;
      chk("t4_cnt_full", ar_cnt, 4'd8);
      chk("t4_full", ar_full, 1'b1);
      push_ar(2'd1);
      chk("t4_drop_cnt", ar_cnt, 4'd8);
      drive(3, 32'hE0, 1'b1, 1'b1);
      tick();
      drive(3, 32'h0, 1'b0, 1'b0);
      push_ar(2'd2);
      chk("t4_pushpop_cnt", ar_cnt, 4'd8);
      chk("t4_pushpop_full", ar_full, 1'b1);
      for (int i = 0; i < 7; i++) begin
         drive(3, 32'hF0 + i, 1'b1, 1'b1);
         if (i == 0) drive(2, 32'h60, 1'b1, 1'b1);
         tick();
         if (i == 0) drive(2, 32'h0, 1'b0, 1'b0);
      end
      drive(3, 32'h0, 1'b0, 1'b0);
      repeat (6) tick();
      chk("t4_nbeats", q_dat.size(), 9);
      chk("t4_first", q_dat[0], 32'hE0);
      for (int i = 0; i < 7; i++) chk("t4_mid", q_dat[i + 1], 32'hF0 + i);
      chk("t4_new_entry", q_dat[8], 32'h60);
      chk("t4_new_rid", q_id[8], 5'd3);
      chk("t4_cnt_end", ar_cnt, 4'd0);
      chk("t4_full_end", ar_full, 1'b0);

      // ---- test 5: reset in the middle of a 4-beat burst
      m_rready = 1'b0;
      clear_q();
      push_ar(2'd1);
      drive(1, 32'hD0, 1'b0, 1'b1);
      tick();
      drive(1, 32'hD1, 1'b0, 1'b1);
      tick();
      drive(1, 32'h0, 1'b0, 1'b0);
      repeat (2) tick();
      chk("t5_pre_vld", m_rvalid, 1'b1);
      chk("t5_pre_data", m_rdata, 32'hD0);
      #2 ARESET = 1'b1;
      #1;
      chk("t5_rst_vld", m_rvalid, 1'b0);
      chk("t5_rst_data", m_rdata, 32'h0);
      chk("t5_rst_cnt", ar_cnt, 4'd0);
      chk("t5_rst_rready", sa_rready, 4'h0);
      @(posedge ACLK);
      #3 ARESET = 1'b0;
      tick();
      chk("t5_post_rready", sa_rready, 4'hF);
      chk("t5_post_vld", m_rvalid, 1'b0);
      chk("t5_post_cnt", ar_cnt, 4'd0);
      m_rready = 1'b1;
      repeat (3) tick();
      chk("t5_no_leftover", q_dat.size(), 0);
      push_ar(2'd1);
      drive(1, 32'hD7, 1'b1, 1'b1);
      tick();
      drive(1, 32'h0, 1'b0, 1'b0);
      repeat (3) tick();
      chk("t5_fresh_n", q_dat.size(), 1);
      chk("t5_fresh_data", q_dat[0], 32'hD7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
